// File: rtl/echo_delay_engine_if.sv
// Memory-side bus between the echo engine (master) and the 64K x 16 SPRAM block (slave).
// Read data is returned the cycle after an address is presented with mem_wren low.
interface echo_delay_engine_if #(
  parameter int ADDRLEN = 16,
  parameter int DATALEN = 16
);
  logic [ADDRLEN-1:0] mem_addr;
  logic [DATALEN-1:0] mem_datain;
  logic               mem_wren;
  logic [DATALEN-1:0] mem_dataout;

  modport master (
    output mem_addr,
    output mem_datain,
    output mem_wren,
    input  mem_dataout
  );

  modport slave (
    input  mem_addr,
    input  mem_datain,
    input  mem_wren,
    output mem_dataout
  );
endinterface

// File: rtl/echo_delay_engine.sv
// Feedback echo line: per sample, read the delayed word, mix y = sat(x + (d*fb)>>>FBLEN),
// write y back at the write pointer and present it on sample_out.
module echo_delay_engine #(
  parameter int ADDRLEN = 16,
  parameter int DATALEN = 16,
  parameter int FBLEN   = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [DATALEN-1:0]  sample_in,
  input  logic                sample_valid,
  input  logic [ADDRLEN-1:0]  delay,
  input  logic [FBLEN-1:0]    feedback,
  output logic [DATALEN-1:0]  sample_out,
  output logic                sample_out_valid,
  output logic                busy,
  output logic                overrun,
  echo_delay_engine_if.master mem
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam logic [ADDRLEN-1:0] PTR_ONE = {{(ADDRLEN-1){1'b0}}, 1'b1};

  function automatic logic [DATALEN-1:0] sat_fn(input logic [DATALEN:0] s);
    logic [DATALEN-1:0] r;
    if (s[DATALEN] != s[DATALEN-1]) begin
      r = s[DATALEN] ? {1'b1, {(DATALEN-1){1'b0}}} : {1'b0, {(DATALEN-1){1'b1}}};
    end else begin
      r = s[DATALEN-1:0];
    end
    return r;
  endfunction

  // Operands are extended to the full product width so the unsigned multiply yields the signed result.
  function automatic logic [DATALEN-1:0] mix_fn(input logic [DATALEN-1:0] x,
                                                input logic [DATALEN-1:0] d,
                                                input logic [FBLEN-1:0]   g);
    logic [DATALEN+FBLEN:0]        a;
    logic [DATALEN+FBLEN:0]        b;
    logic signed [DATALEN+FBLEN:0] p;
    logic signed [DATALEN+FBLEN:0] q;
    logic [DATALEN:0]              s;
    a = {{(FBLEN+1){d[DATALEN-1]}}, d};
    b = {{DATALEN{1'b0}}, 1'b0, g};
    p = a * b;
    q = p >>> FBLEN;
    s = {x[DATALEN-1], x} + q[DATALEN:0];
    return sat_fn(s);
  endfunction

  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [DATALEN-1:0] in_x_q, in_x_d;
  logic [ADDRLEN-1:0] in_dly_q, in_dly_d;
  logic [FBLEN-1:0]   in_fb_q, in_fb_d;
  logic [DATALEN-1:0] x_q, x_d;
  logic [ADDRLEN-1:0] dly_q, dly_d;
  logic [FBLEN-1:0]   g_q, g_d;
  logic [ADDRLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic               filled_q, filled_d;
  logic [DATALEN-1:0] y_q, y_d;
  logic [DATALEN-1:0] sample_out_q, sample_out_d;
  logic               sample_out_valid_q, sample_out_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic [ADDRLEN-1:0] mem_addr_q, mem_addr_d;
  logic [DATALEN-1:0] mem_datain_q, mem_datain_d;
  logic               mem_wren_q, mem_wren_d;

  logic               accept_s;
  logic               mask_s;
  logic [DATALEN-1:0] d_s;
  logic [DATALEN-1:0] mix_s;

  // Staging, next-state, datapath and output computation for the one-sample transaction.
  always_comb begin
    state_d            = state_q;
    in_x_d             = in_x_q;
    in_dly_d           = in_dly_q;
    in_fb_d            = in_fb_q;
    x_d                = x_q;
    dly_d              = dly_q;
    g_d                = g_q;
    wr_ptr_d           = wr_ptr_q;
    filled_d           = filled_q;
    y_d                = y_q;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    mem_addr_d         = mem_addr_q;
    mem_datain_d       = mem_datain_q;
    mem_wren_d         = 1'b0;

    // A strobe is taken only when nothing is pending or in flight; any other strobe is an overrun.
    accept_s  = sample_valid && (state_q == IDLE) && !pend_q;
    pend_d    = accept_s;
    overrun_d = overrun_q | (sample_valid & ~accept_s);
    if (accept_s) begin
      in_x_d   = sample_in;
      in_dly_d = delay;
      in_fb_d  = feedback;
    end else begin
      in_x_d   = in_x_q;
      in_dly_d = in_dly_q;
      in_fb_d  = in_fb_q;
    end

    // Locations never written since reset read back as silence.
    mask_s = !filled_q && ((dly_q == {ADDRLEN{1'b0}}) || (dly_q > wr_ptr_q));
    if (mask_s) begin
      d_s = {DATALEN{1'b0}};
    end else begin
      d_s = mem.mem_dataout;
    end
    mix_s = mix_fn(x_q, d_s, g_q);

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          x_d        = in_x_q;
          dly_d      = in_dly_q;
          g_d        = in_fb_q;
          mem_addr_d = wr_ptr_q - in_dly_q;
          state_d    = READ;
        end else begin
          state_d    = IDLE;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        y_d          = mix_s;
        mem_addr_d   = wr_ptr_q;
        mem_datain_d = mix_s;
        mem_wren_d   = 1'b1;
        state_d      = WRITE;
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (wr_ptr_q == {ADDRLEN{1'b1}}) begin
          filled_d = 1'b1;
        end else begin
          filled_d = filled_q;
        end
        sample_out_d       = y_q;
        sample_out_valid_d = 1'b1;
        state_d            = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction without a write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q            <= IDLE;
      pend_q             <= 1'b0;
      in_x_q             <= {DATALEN{1'b0}};
      in_dly_q           <= {ADDRLEN{1'b0}};
      in_fb_q            <= {FBLEN{1'b0}};
      x_q                <= {DATALEN{1'b0}};
      dly_q              <= {ADDRLEN{1'b0}};
      g_q                <= {FBLEN{1'b0}};
      wr_ptr_q           <= {ADDRLEN{1'b0}};
      filled_q           <= 1'b0;
      y_q                <= {DATALEN{1'b0}};
      sample_out_q       <= {DATALEN{1'b0}};
      sample_out_valid_q <= 1'b0;
      busy_q             <= 1'b0;
      overrun_q          <= 1'b0;
      mem_addr_q         <= {ADDRLEN{1'b0}};
      mem_datain_q       <= {DATALEN{1'b0}};
      mem_wren_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      pend_q             <= pend_d;
      in_x_q             <= in_x_d;
      in_dly_q           <= in_dly_d;
      in_fb_q            <= in_fb_d;
      x_q                <= x_d;
      dly_q              <= dly_d;
      g_q                <= g_d;
      wr_ptr_q           <= wr_ptr_d;
      filled_q           <= filled_d;
      y_q                <= y_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      busy_q             <= busy_d;
      overrun_q          <= overrun_d;
      mem_addr_q         <= mem_addr_d;
      mem_datain_q       <= mem_datain_d;
      mem_wren_q         <= mem_wren_d;
    end
  end

  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;
  assign mem.mem_addr     = mem_addr_q;
  assign mem.mem_datain   = mem_datain_q;
  assign mem.mem_wren     = mem_wren_q;

endmodule

// File: tb/tb_echo_delay_engine.sv
// Scoreboarded bench for echo_delay_engine: a history-based echo model predicts read address,
// write address/data and output for each accepted sample; a monitor compares as the DUT emits them.
module tb_echo_delay_engine;
  localparam int AL = 10;
  localparam int DL = 16;
  localparam int FL = 8;
  localparam int N  = 1 << AL;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DL-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [AL-1:0] delay = '0;
  logic [FL-1:0] feedback = '0;
  logic [DL-1:0] sample_out;
  logic          sample_out_valid;
  logic          busy;
  logic          overrun;

  echo_delay_engine_if #(.ADDRLEN(AL), .DATALEN(DL)) mem_if ();

  echo_delay_engine #(.ADDRLEN(AL), .DATALEN(DL), .FBLEN(FL)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .delay            (delay),
    .feedback         (feedback),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .busy             (busy),
    .overrun          (overrun),
    .mem              (mem_if.master)
  );

  always #5 clk = ~clk;

  // SPRAM model; the fill port preloads garbage that must never leak through the mask.
  logic [DL-1:0] ram [N];
  logic          fill_en = 1'b0;
  logic [AL-1:0] fill_addr = '0;
  logic [DL-1:0] fill_data = '0;
  always @(posedge clk) begin
    if (fill_en) ram[fill_addr] <= fill_data;
    else if (mem_if.mem_wren) ram[mem_if.mem_addr] <= mem_if.mem_datain;
    else mem_if.mem_dataout <= ram[mem_if.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int k; int ra; int wa; int y; } txn_t;
  txn_t rd_q[$];
  txn_t wr_q[$];
  txn_t out_q[$];
  int   hist[$];
  int   n_acc = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Echo model: output n is x plus the gained output from D samples ago, if one exists.
  task automatic issue(input int x, input int dly, input int fb);
    txn_t t;
    int   dd, d, s;
    dd = (dly == 0) ? N : dly;
    d  = (n_acc >= dd) ? hist[n_acc - dd] : 0;
    s  = x + ((d * fb) >>> 8);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    t.k  = cyc + 1;
    t.ra = (((n_acc - dd) % N) + N) % N;
    t.wa = n_acc % N;
    t.y  = s;
    rd_q.push_back(t);
    wr_q.push_back(t);
    out_q.push_back(t);
    hist.push_back(s);
    n_acc++;
    sample_in    = x[DL-1:0];
    delay        = dly[AL-1:0];
    feedback     = fb[FL-1:0];
    sample_valid = 1'b1;
  endtask

  task automatic send(input int x, input int dly, input int fb, input int gap);
    @(negedge clk);
    issue(x, dly, fb);
    @(negedge clk);
    sample_valid = 1'b0;
    delay        = AL'($urandom);
    feedback     = FL'($urandom);
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((rd_q.size() + wr_q.size() + out_q.size()) != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", rd_q.size() + wr_q.size() + out_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample_out"}, int'(sample_out), 0);
    check({tag, "_out_valid"}, int'(sample_out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_mem_addr"}, int'(mem_if.mem_addr), 0);
    check({tag, "_mem_datain"}, int'(mem_if.mem_datain), 0);
    check({tag, "_mem_wren"}, int'(mem_if.mem_wren), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    rd_q.delete();
    wr_q.delete();
    out_q.delete();
    hist.delete();
    n_acc = 0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: compare each DUT emission against the oldest outstanding expectation.
  always @(negedge clk) begin
    txn_t t;
    if (resetn) begin
      if (rd_q.size() > 0 && rd_q[0].k + 1 == cyc) begin
        t = rd_q.pop_front();
        check("read_addr", int'(mem_if.mem_addr), t.ra);
        check("read_wren", int'(mem_if.mem_wren), 0);
      end
      if (mem_if.mem_wren) begin
        if (wr_q.size() == 0) begin
          check("spurious_wren", 1, 0);
        end else begin
          t = wr_q.pop_front();
          check("write_addr", int'(mem_if.mem_addr), t.wa);
          check("write_data", int'($signed(mem_if.mem_datain)), t.y);
          check("write_cycle", cyc, t.k + 3);
        end
      end
      if (sample_out_valid) begin
        if (out_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          t = out_q.pop_front();
          check("sample_out", int'($signed(sample_out)), t.y);
          check("out_cycle", cyc, t.k + 4);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly;
    // Preload the memory with garbage while the DUT is held in reset.
    fill_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      fill_addr = i[AL-1:0];
      fill_data = DL'($urandom);
    end
    @(negedge clk);
    fill_en = 1'b0;
    #1;
    check_reset_outputs("init");
    do_reset();

    // Reset asserted during CAPTURE: no write, outputs cleared, pointer restarts.
    @(negedge clk);
    sample_in = 16'd777; delay = 10'd1; feedback = 8'd255; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_in_capture", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_wren", int'(mem_if.mem_wren), 0);
    end
    resetn = 1'b1;
    send(5, 4, 0, 6);
    drain();

    // Dry path.
    do_reset();
    send(100, 4, 0, 5);
    send(-200, 4, 0, 5);
    send(32767, 4, 0, 5);
    drain();

    // Echo with masked reads of never-written locations.
    do_reset();
    send(16384, 3, 128, 5);
    for (int i = 0; i < 6; i++) send(0, 3, 128, 5);
    drain();

    // Saturation, both directions.
    do_reset();
    send(30000, 1, 255, 5);
    send(30000, 1, 255, 5);
    do_reset();
    send(-30000, 1, 255, 5);
    send(-30000, 1, 255, 5);
    drain();

    // Overrun: second strobe two cycles after the first is dropped.
    do_reset();
    @(negedge clk);
    issue(1234, 2, 64);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    sample_in = 16'd999; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("overrun_set", int'(overrun), 1);
    send(-50, 1, 200, 6);
    drain();
    check("overrun_sticky", int'(overrun), 1);

    // Randomized traffic with boundary delays around the write pointer.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: dly = 0;
        1: dly = $urandom_range(1, 8);
        2: dly = n_acc % N;
        default: dly = (n_acc + 1) % N;
      endcase
      send($urandom_range(0, 65535) - 32768, dly, $urandom_range(0, 255), $urandom_range(5, 9));
    end
    drain();

    // Full ring wrap, then reads that depend on the ring having been filled.
    do_reset();
    for (int n = 0; n < N; n++) send(n & 32'h7FFF, 0, 0, 5);
    send(0, 0, 255, 5);
    send(0, 5, 255, 5);
    drain();
    check("overrun_clear_wrap", int'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
